// File: rtl/dds_sweep_nco.sv
// Quadrature NCO: quarter-wave sine table, shadowed FREQ/PHASE_OFS, phase sync and linear chirp.
// Optional build macro DDS_DITHER_EN adds LFSR phase dither below the table index LSB.
module dds_sweep_nco #(
  parameter int unsigned PHASE_W  = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned OUT_W    = 16,
  parameter string       ROM_FILE = "qsin.hex"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic [PHASE_W-1:0]        cfg_data,
  input  logic                      cfg_commit,
  input  logic                      phase_sync,
  input  logic                      sweep_start,
  input  logic                      sweep_abort,
  output logic signed [OUT_W-1:0]   sine,
  output logic signed [OUT_W-1:0]   cose,
  output logic                      out_valid,
  output logic                      sweep_busy,
  output logic                      sweep_done
);

  localparam int unsigned QW  = ADDR_W - 2;
  localparam int unsigned QN  = 1 << QW;
  localparam int unsigned XW  = PHASE_W + 2;
  localparam longint      Amp = (longint'(1) <<< (OUT_W - 1)) - 1;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  // Same contents as ROM_FILE, computed at elaboration so the table has no file dependency.
  function automatic logic [OUT_W-2:0] qsin_entry(input int unsigned k);
    longint pi_q32;
    longint x, x2, term, sum;
    pi_q32 = 64'sh3_243F_6A88;
    x      = (pi_q32 * longint'(2 * k + 1)) >>> (ADDR_W + 2);
    x2     = (x * x) >>> 30;
    term   = x;
    sum    = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return (OUT_W - 1)'((sum * Amp + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [OUT_W-2:0] qtab [QN];
  for (genvar k = 0; k < QN; k++) begin : g_qtab
    localparam logic [OUT_W-2:0] Entry = qsin_entry(k);
    assign qtab[k] = Entry;
  end

  logic [PHASE_W-1:0] sh_freq_q, sh_freq_d, sh_ofs_q, sh_ofs_d;
  logic [PHASE_W-1:0] sw_start_q, sw_start_d, sw_step_q, sw_step_d;
  logic [PHASE_W-1:0] sw_stop_q, sw_stop_d, sw_dwell_q, sw_dwell_d;
  logic [PHASE_W-1:0] freq_q, freq_d, ofs_q, ofs_d, acc_q, acc_d, dwell_q, dwell_d;
  state_e             state_q, state_d;

  logic [ADDR_W-1:0]       sin_idx_q, sin_idx_d, cos_idx_q, cos_idx_d;
  logic [OUT_W-2:0]        sin_mag_q, sin_mag_d, cos_mag_q, cos_mag_d;
  logic                    sin_neg_q, sin_neg_d, cos_neg_q, cos_neg_d;
  logic signed [OUT_W-1:0] sine_q, sine_d, cose_q, cose_d;
  logic [2:0]              vld_q, vld_d;
  logic [1:0]              warm_q, warm_d;

  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  sin_idx, cos_idx;
  logic [QW-1:0]      sin_addr, cos_addr;
  logic signed [OUT_W-1:0] sin_mag_s, cos_mag_s;
  logic signed [XW-1:0]    nf_x, stop_x;
  logic                    sweep_end;

`ifdef DDS_DITHER_EN
  localparam int unsigned FracW = PHASE_W - ADDR_W;
  localparam int unsigned DitW  = (FracW > 16) ? 16 : FracW;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [PHASE_W-1:0] dither;

  always_comb begin
    lfsr_d = lfsr_q;
    if (ce) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    dither = PHASE_W'(lfsr_q[15 -: DitW]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign phase = acc_q + ofs_q + dither;
`else
  assign phase = acc_q + ofs_q;
`endif

  assign sin_idx   = ADDR_W'(phase >> (PHASE_W - ADDR_W));
  assign cos_idx   = sin_idx + ADDR_W'(QN);
  assign sin_addr  = sin_idx_q[ADDR_W-2] ? ~sin_idx_q[QW-1:0] : sin_idx_q[QW-1:0];
  assign cos_addr  = cos_idx_q[ADDR_W-2] ? ~cos_idx_q[QW-1:0] : cos_idx_q[QW-1:0];
  assign sin_mag_s = signed'({1'b0, sin_mag_q});
  assign cos_mag_s = signed'({1'b0, cos_mag_q});

  // Two guard bits make overshoot and wrap in either step direction compare correctly.
  assign nf_x      = signed'({2'b00, freq_q}) + signed'({{2{sw_step_q[PHASE_W-1]}}, sw_step_q});
  assign stop_x    = signed'({2'b00, sw_stop_q});
  assign sweep_end = (sw_step_q == '0) ||
                     (sw_step_q[PHASE_W-1] ? (nf_x <= stop_x) : (nf_x >= stop_x));

  always_comb begin
    sh_freq_d  = sh_freq_q;
    sh_ofs_d   = sh_ofs_q;
    sw_start_d = sw_start_q;
    sw_step_d  = sw_step_q;
    sw_stop_d  = sw_stop_q;
    sw_dwell_d = sw_dwell_q;
    if (cfg_we) begin
      unique case (cfg_addr)
        3'd0:    sh_freq_d  = cfg_data;
        3'd1:    sh_ofs_d   = cfg_data;
        3'd2:    sw_start_d = cfg_data;
        3'd3:    sw_step_d  = cfg_data;
        3'd4:    sw_stop_d  = cfg_data;
        3'd5:    sw_dwell_d = cfg_data;
        default: ;
      endcase
    end
    ofs_d = cfg_commit ? sh_ofs_q : ofs_q;
    acc_d = phase_sync ? '0 : (ce ? acc_q + freq_q : acc_q);
  end

  // Active frequency is owned by the sweep engine while busy; commits only land outside SWEEP.
  always_comb begin
    freq_d  = freq_q;
    dwell_d = dwell_q;
    if (!sweep_abort && state_q == StIdle && sweep_start) begin
      freq_d  = sw_start_q;
      dwell_d = sw_dwell_q;
    end else if (!sweep_abort && state_q == StSweep && ce) begin
      if (dwell_q == '0) begin
        dwell_d = sw_dwell_q;
        freq_d  = sweep_end ? sw_stop_q : nf_x[PHASE_W-1:0];
      end else begin
        dwell_d = dwell_q - PHASE_W'(1);
      end
    end else if (cfg_commit && state_q != StSweep) begin
      freq_d = sh_freq_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sweep_start) state_d = StSweep;
      StSweep: if (ce && dwell_q == '0 && sweep_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (sweep_abort) state_d = StIdle;
  end

  always_comb begin
    sweep_busy = (state_q == StSweep);
    sweep_done = (state_q == StDone);
  end

  always_comb begin
    sin_idx_d = sin_idx_q;
    cos_idx_d = cos_idx_q;
    sin_neg_d = sin_neg_q;
    cos_neg_d = cos_neg_q;
    sin_mag_d = sin_mag_q;
    cos_mag_d = cos_mag_q;
    sine_d    = sine_q;
    cose_d    = cose_q;
    if (ce) begin
      sin_idx_d = sin_idx;
      cos_idx_d = cos_idx;
      sin_neg_d = sin_idx_q[ADDR_W-1];
      cos_neg_d = cos_idx_q[ADDR_W-1];
      sin_mag_d = qtab[sin_addr];
      cos_mag_d = qtab[cos_addr];
      sine_d    = sin_neg_q ? -sin_mag_s : sin_mag_s;
      cose_d    = cos_neg_q ? -cos_mag_s : cos_mag_s;
    end
    vld_d  = {vld_q[1:0], ce};
    warm_d = (ce && warm_q != 2'd3) ? warm_q + 2'd1 : warm_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_freq_q  <= '0;
      sh_ofs_q   <= '0;
      sw_start_q <= '0;
      sw_step_q  <= '0;
      sw_stop_q  <= '0;
      sw_dwell_q <= '0;
      freq_q     <= '0;
      ofs_q      <= '0;
      acc_q      <= '0;
      dwell_q    <= '0;
      sin_idx_q  <= '0;
      cos_idx_q  <= '0;
      sin_neg_q  <= 1'b0;
      cos_neg_q  <= 1'b0;
      sin_mag_q  <= '0;
      cos_mag_q  <= '0;
      sine_q     <= '0;
      cose_q     <= '0;
      vld_q      <= '0;
      warm_q     <= '0;
    end else begin
      sh_freq_q  <= sh_freq_d;
      sh_ofs_q   <= sh_ofs_d;
      sw_start_q <= sw_start_d;
      sw_step_q  <= sw_step_d;
      sw_stop_q  <= sw_stop_d;
      sw_dwell_q <= sw_dwell_d;
      freq_q     <= freq_d;
      ofs_q      <= ofs_d;
      acc_q      <= acc_d;
      dwell_q    <= dwell_d;
      sin_idx_q  <= sin_idx_d;
      cos_idx_q  <= cos_idx_d;
      sin_neg_q  <= sin_neg_d;
      cos_neg_q  <= cos_neg_d;
      sin_mag_q  <= sin_mag_d;
      cos_mag_q  <= cos_mag_d;
      sine_q     <= sine_d;
      cose_q     <= cose_d;
      vld_q      <= vld_d;
      warm_q     <= warm_d;
    end
  end

  assign sine      = sine_q;
  assign cose      = cose_q;
  assign out_valid = vld_q[2] && (warm_q == 2'd3);

endmodule
